gps_emu_scheduler: RTL

- Configuration controller for the satellite emulator datapath.
- A host or test sequencer writes per-satellite Doppler frequency, gain and C/A select, plus noise gain and a run bit, into shadow registers over a valid/ready write port.
- A commit copies shadow to active atomically. While running, the copy is aligned to the next C/A code epoch (1 ms); while stopped, it happens immediately.
- Active registers drive the emulator's freq/gain/ca_sel/noise_gain/enable inputs directly.

---
 rtl/gps_emu_pkg.sv | 30 +++
 rtl/gps_chan_cfg_bank.sv | 64 ++++++
 rtl/gps_emu_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gps_emu_pkg.sv
// Shared constants, register map and scheduler state type for the GPS emulator
// configuration controller.
package gps_emu_pkg;

    localparam int NSAT_MAX   = 32;
    localparam int CA_SEL_MAX = 35;
    localparam int CA_SEL_W   = 6;

    localparam int ADDR_NOISE = 'hF0;
    localparam int ADDR_CTRL  = 'hF1;

    localparam logic [1:0] OFF_FREQ   = 2'd0;
    localparam logic [1:0] OFF_GAIN   = 2'd1;
    localparam logic [1:0] OFF_CA_SEL = 2'd2;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_RUN     = 1;
    localparam int CTRL_ERR_CLR = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } sched_state_t;

    function automatic logic ca_sel_ok(input logic [CA_SEL_W-1:0] v);
        return v <= CA_SEL_W'(CA_SEL_MAX);
    endfunction

endpackage

// File: rtl/gps_chan_cfg_bank.sv
// One satellite channel: host-written shadow registers and the active copy that
// drives the emulator, refreshed from shadow on the apply strobe.
module gps_chan_cfg_bank
    import gps_emu_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_freq,
    input  logic                wr_gain,
    input  logic                wr_ca_sel,
    input  logic [31:0]         wr_data,
    input  logic                apply,
    output logic [31:0]         freq,
    output logic [15:0]         gain,
    output logic [CA_SEL_W-1:0] ca_sel
);

    logic [31:0]         sh_freq_q, sh_freq_d, act_freq_q, act_freq_d;
    logic [15:0]         sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;
    logic [CA_SEL_W-1:0] sh_ca_sel_q, sh_ca_sel_d, act_ca_sel_q, act_ca_sel_d;

    always_comb begin
        sh_freq_d    = sh_freq_q;
        sh_gain_d    = sh_gain_q;
        sh_ca_sel_d  = sh_ca_sel_q;
        act_freq_d   = act_freq_q;
        act_gain_d   = act_gain_q;
        act_ca_sel_d = act_ca_sel_q;

        if (wr_freq)   sh_freq_d   = wr_data;
        if (wr_gain)   sh_gain_d   = wr_data[15:0];
        if (wr_ca_sel) sh_ca_sel_d = wr_data[CA_SEL_W-1:0];

        if (apply) begin
            act_freq_d   = sh_freq_q;
            act_gain_d   = sh_gain_q;
            act_ca_sel_d = sh_ca_sel_q;
        end
    end

    // NOTE: shadow is reset as well, so a commit issued before any write applies zeros.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_freq_q    <= '0;
            sh_gain_q    <= '0;
            sh_ca_sel_q  <= '0;
            act_freq_q   <= '0;
            act_gain_q   <= '0;
            act_ca_sel_q <= '0;
        end else begin
            sh_freq_q    <= sh_freq_d;
            sh_gain_q    <= sh_gain_d;
            sh_ca_sel_q  <= sh_ca_sel_d;
            act_freq_q   <= act_freq_d;
            act_gain_q   <= act_gain_d;
            act_ca_sel_q <= act_ca_sel_d;
        end
    end

    assign freq   = act_freq_q;
    assign gain   = act_gain_q;
    assign ca_sel = act_ca_sel_q;

endmodule

// File: rtl/gps_emu_scheduler.sv
// Configuration controller: decodes host writes into shadow registers and copies
// shadow to active atomically, aligned to the C/A epoch while the emulator runs.
module gps_emu_scheduler
    import gps_emu_pkg::*;
#(
    parameter int Nsat = 4,
    parameter int AW   = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     code_epoch,
    output logic [32*Nsat-1:0]       freq,
    output logic [16*Nsat-1:0]       gain,
    output logic [CA_SEL_W*Nsat-1:0] ca_sel,
    output logic [15:0]              noise_gain,
    output logic                     enable,
    output logic                     commit_done,
    output logic                     busy,
    output logic                     err
);

    sched_state_t state_q, state_d;
    logic [15:0]  noise_sh_q, noise_sh_d, noise_act_q, noise_act_d;
    logic         run_q, run_d, enable_q, enable_d, err_q, err_d;

    logic            wr_fire, in_bank, commit_wr, err_set, err_clr, apply;
    logic [Nsat-1:0] wr_freq_s, wr_gain_s, wr_ca_sel_s;

    assign wr_fire = wr_valid && wr_ready;
    assign in_bank = int'(wr_addr) < 4 * Nsat;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        noise_sh_d  = noise_sh_q;
        noise_act_d = noise_act_q;
        run_d       = run_q;
        enable_d    = enable_q;
        err_d       = err_q;
        state_d     = state_q;
        wr_freq_s   = '0;
        wr_gain_s   = '0;
        wr_ca_sel_s = '0;
        commit_wr   = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        apply       = 1'b0;

        if (wr_fire) begin
            if (wr_addr == AW'(ADDR_NOISE)) begin
                noise_sh_d = wr_data[15:0];
            end else if (wr_addr == AW'(ADDR_CTRL)) begin
                run_d     = wr_data[CTRL_RUN];
                commit_wr = wr_data[CTRL_COMMIT];
                err_clr   = wr_data[CTRL_ERR_CLR];
            end else if (in_bank) begin
                for (int s = 0; s < Nsat; s++) begin
                    if (int'(wr_addr[AW-1:2]) == s) begin
                        case (wr_addr[1:0])
                            OFF_FREQ: wr_freq_s[s] = 1'b1;
                            OFF_GAIN: wr_gain_s[s] = 1'b1;
                            OFF_CA_SEL: begin
                                // Out-of-range PRN select is swallowed; shadow keeps its old value.
                                if (ca_sel_ok(wr_data[CA_SEL_W-1:0])) wr_ca_sel_s[s] = 1'b1;
                                else                                  err_set        = 1'b1;
                            end
                            default: err_set = 1'b1;
                        endcase
                    end
                end
            end else begin
                err_set = 1'b1;
            end
        end

        // A stopped emulator produces no epochs, so its commits apply immediately.
        case (state_q)
            IDLE: begin
                if (commit_wr) begin
                    if (enable_q) begin
                        state_d = ARMED;
                    end else begin
                        state_d = APPLY;
                        apply   = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (code_epoch) begin
                    state_d = APPLY;
                    apply   = 1'b1;
                end
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (apply) begin
            enable_d    = run_d;
            noise_act_d = noise_sh_q;
        end

        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            noise_sh_q  <= '0;
            noise_act_q <= '0;
            run_q       <= 1'b0;
            enable_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            noise_sh_q  <= noise_sh_d;
            noise_act_q <= noise_act_d;
            run_q       <= run_d;
            enable_q    <= enable_d;
            err_q       <= err_d;
        end
    end

    for (genvar s = 0; s < Nsat; s++) begin : g_chan
        gps_chan_cfg_bank u_bank (
            .clk       (clk),
            .rstn      (rstn),
            .wr_freq   (wr_freq_s[s]),
            .wr_gain   (wr_gain_s[s]),
            .wr_ca_sel (wr_ca_sel_s[s]),
            .wr_data   (wr_data),
            .apply     (apply),
            .freq      (freq[32*s +: 32]),
            .gain      (gain[16*s +: 16]),
            .ca_sel    (ca_sel[CA_SEL_W*s +: CA_SEL_W])
        );
    end

    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign commit_done = (state_q == APPLY);
    assign noise_gain  = noise_act_q;
    assign enable      = enable_q;
    assign err         = err_q;

endmodule
